// File: rtl/sdio_pkg.sv
// rtl/sdio_pkg.sv - shared encodings and frame constants for the SDIO register master
// Contents: FSM state encoding, header codes, frame-length constants, GAP length.
package sdio_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SEND      = 3'd1,
      ST_WAIT_MARK = 3'd2,
      ST_RDATA     = 3'd3,
      ST_GAP       = 3'd4
   } state_e;

   localparam logic [1:0] HDR_RD = 2'b10;
   localparam logic [1:0] HDR_WR = 2'b11;

   // Frame length beyond the address: read = header(2) + turn(1),
   // write = header(2) + data(32) + turn(1).
   localparam int RD_EXTRA = 3;
   localparam int WR_EXTRA = 35;

   localparam int DATA_W  = 32;
   localparam int GAP_LEN = 2;

endpackage

// File: rtl/sdio_sck_gen.sv
// rtl/sdio_sck_gen.sv - sdio_sck divider with one-clk rise/fall ticks
// Ports:
//   clk, rst      block clock, asynchronous active-low reset
//   run_i         1 = toggle sck; 0 = hold sck low and restart the phase counter
//   sck_o         registered serial clock (low phase first)
//   rise_o/fall_o high in the clk whose rising edge moves sck_o up/down
module sdio_sck_gen #(
   parameter int HALF_DIV = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic run_i,
   output logic sck_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int DW = $clog2(HALF_DIV);

   logic [DW-1:0] cnt_q;
   logic          sck_q;
   logic          last;

   // Ticks are combinational so the FSM updates mosi/samples miso on the
   // very edge that moves sck, keeping data and clock aligned.
   assign last   = run_i && (cnt_q == DW'(HALF_DIV - 1));
   assign rise_o = last && !sck_q;
   assign fall_o = last && sck_q;
   assign sck_o  = sck_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         sck_q <= 1'b0;
      end else if (!run_i) begin
         cnt_q <= '0;
         sck_q <= 1'b0;
      end else if (last) begin
         cnt_q <= '0;
         sck_q <= !sck_q;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/sdio_master.sv
// rtl/sdio_master.sv - serial register-access master (read/write frames, marker wait, timeout)
// Ports:
//   clk, rst                 block clock, asynchronous active-low reset
//   cmd_valid/cmd_ready      command handshake; cmd_wr, cmd_addr, cmd_wdata fields
//   rsp_valid                one-clk completion pulse; rsp_rdata, rsp_err qualified by it
//   sdio_sck, sdio_mosi      serial clock and data to the slave
//   sdio_miso                asynchronous serial data from the slave
module sdio_master
   import sdio_pkg::*;
#(
   parameter int AW       = 8,
   parameter int HALF_DIV = 8,
   parameter int TMO      = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_wr,
   input  logic [AW-1:0] cmd_addr,
   input  logic [31:0]   cmd_wdata,
   output logic          rsp_valid,
   output logic [31:0]   rsp_rdata,
   output logic          rsp_err,
   output logic          sdio_sck,
   output logic          sdio_mosi,
   input  logic          sdio_miso
);

   localparam int FW = AW + WR_EXTRA;
   // One counter serves frame bits, marker timeout, read data and GAP.
   localparam int CW = $clog2(FW + TMO + DATA_W + 1);

   state_e        state_q;
   logic [FW-1:0] sr_q;
   logic [CW-1:0] cnt_q;
   logic          wr_q;
   logic          err_q;
   logic [31:0]   rdata_q;
   logic          mosi_q;
   logic          ready_q;
   logic          rsp_valid_q;
   logic [31:0]   rsp_rdata_q;
   logic          rsp_err_q;
   logic [1:0]    sync_q;

   logic [FW-1:0] frame_d;
   logic [CW-1:0] len_d;
   logic          miso_s;
   logic          run;
   logic          rise;
   logic          fall;

   assign miso_s = sync_q[1];
   assign run    = (state_q != ST_IDLE);

   // Frames are left-aligned in the shift register; a read frame is padded
   // with zeros that are never clocked out.
   always_comb begin
      frame_d = '0;
      len_d   = '0;
      if (cmd_wr) begin
         frame_d = {HDR_WR, cmd_addr, cmd_wdata, 1'b0};
         len_d   = CW'(AW + WR_EXTRA);
      end else begin
         frame_d = {HDR_RD, cmd_addr, 1'b0, 32'h0};
         len_d   = CW'(AW + RD_EXTRA);
      end
   end

   sdio_sck_gen #(
      .HALF_DIV (HALF_DIV)
   ) u_sck_gen (
      .clk    (clk),
      .rst    (rst),
      .run_i  (run),
      .sck_o  (sdio_sck),
      .rise_o (rise),
      .fall_o (fall)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         sr_q        <= '0;
         cnt_q       <= '0;
         wr_q        <= 1'b0;
         err_q       <= 1'b0;
         rdata_q     <= '0;
         mosi_q      <= 1'b0;
         ready_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         sync_q      <= '0;
      end else begin
         sync_q      <= {sync_q[0], sdio_miso};
         rsp_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (cmd_valid && ready_q) begin
                  sr_q    <= frame_d;
                  cnt_q   <= len_d;
                  wr_q    <= cmd_wr;
                  err_q   <= 1'b0;
                  rdata_q <= '0;
                  ready_q <= 1'b0;
                  state_q <= ST_SEND;
               end else begin
                  ready_q <= 1'b1;
               end
            end
            ST_SEND: begin
               if (rise) begin
                  mosi_q <= sr_q[FW-1];
                  sr_q   <= {sr_q[FW-2:0], 1'b0};
               end else if (fall) begin
                  if (cnt_q == CW'(1)) begin
                     mosi_q  <= 1'b0;
                     cnt_q   <= CW'(TMO);
                     state_q <= ST_WAIT_MARK;
                  end else begin
                     cnt_q <= cnt_q - 1'b1;
                  end
               end
            end
            ST_WAIT_MARK: begin
               if (fall) begin
                  if (miso_s) begin
                     if (wr_q) begin
                        cnt_q   <= CW'(GAP_LEN);
                        state_q <= ST_GAP;
                     end else begin
                        cnt_q   <= CW'(DATA_W);
                        state_q <= ST_RDATA;
                     end
                  end else if (cnt_q == CW'(1)) begin
                     err_q   <= 1'b1;
                     cnt_q   <= CW'(GAP_LEN);
                     state_q <= ST_GAP;
                  end else begin
                     cnt_q <= cnt_q - 1'b1;
                  end
               end
            end
            ST_RDATA: begin
               if (fall) begin
                  rdata_q <= {rdata_q[30:0], miso_s};
                  if (cnt_q == CW'(1)) begin
                     cnt_q   <= CW'(GAP_LEN);
                     state_q <= ST_GAP;
                  end else begin
                     cnt_q <= cnt_q - 1'b1;
                  end
               end
            end
            ST_GAP: begin
               // Idle sck cycles with mosi low let the slave fall back to
               // waiting for a start bit before the next frame.
               if (fall) begin
                  if (cnt_q == CW'(1)) begin
                     state_q     <= ST_IDLE;
                     ready_q     <= 1'b1;
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= err_q;
                     rsp_rdata_q <= err_q ? 32'h0 : rdata_q;
                  end else begin
                     cnt_q <= cnt_q - 1'b1;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign cmd_ready = ready_q;
   assign sdio_mosi = mosi_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_sdio_master.sv
// tb/tb_sdio_master.sv - self-checking bench for sdio_master with a behavioural register slave
module tb_sdio_master;

   localparam int AW       = 8;
   localparam int HALF_DIV = 4;
   localparam int TMO      = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_wr = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [31:0]   cmd_wdata = '0;
   logic          rsp_valid;
   logic [31:0]   rsp_rdata;
   logic          rsp_err;
   logic          sdio_sck;
   logic          sdio_mosi;
   logic          dut_miso;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int rsp_count = 0;

   // slave model state
   logic [31:0] sl_mem  [256];
   logic [31:0] ref_mem [256];
   bit          sl_tx [$];
   logic [63:0] sl_sr = '0;
   int          sl_n = 0;
   bit          sl_wr = 0;
   bit          sl_prev = 0;
   logic        sl_miso = 1'b0;
   bit          sl_mute = 0;
   int          sl_wr_cnt = 0;
   int          sl_rd_cnt = 0;
   logic [7:0]  sl_last_wa = '0;
   logic [31:0] sl_last_wd = '0;

   assign dut_miso = sl_mute ? 1'b0 : sl_miso;

   sdio_master #(
      .AW       (AW),
      .HALF_DIV (HALF_DIV),
      .TMO      (TMO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_wr    (cmd_wr),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .sdio_sck  (sdio_sck),
      .sdio_mosi (sdio_mosi),
      .sdio_miso (dut_miso)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (rsp_valid) rsp_count <= rsp_count + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Clocks from accept edge to rsp_valid: every sck cycle of the frame is 2*HALF_DIV clks.
   function automatic int exp_clks(input bit wr, input bit tmo);
      int n;
      n = wr ? (2 + AW + 32 + 1) : (2 + AW + 1);
      if (tmo) n += TMO;
      else     n += 1 + (wr ? 0 : 32);
      n += 2;
      return 2 * HALF_DIV * n;
   endfunction

   // Slave: samples mosi when sck falls, drives miso when sck rises.
   initial begin
      logic [7:0]  a;
      forever begin
         @(negedge clk);
         if (!rst) begin
            sl_n = 0;
            sl_tx.delete();
            sl_miso = 1'b0;
            sl_prev = 0;
         end else begin
            if (sdio_sck && !sl_prev)
               sl_miso = (sl_tx.size() > 0) ? sl_tx.pop_front() : 1'b0;
            if (!sdio_sck && sl_prev && (sl_n > 0 || sdio_mosi)) begin
               sl_sr = {sl_sr[62:0], sdio_mosi};
               sl_n++;
               if (sl_n == 2) sl_wr = sdio_mosi;
               if (sl_n >= 2 && sl_n == (sl_wr ? AW + 35 : AW + 3)) begin
                  if (sl_wr) begin
                     a = sl_sr[AW+32:33];
                     sl_mem[a] = sl_sr[32:1];
                     sl_wr_cnt++;
                     sl_last_wa = a;
                     sl_last_wd = sl_sr[32:1];
                     if (!sl_mute) sl_tx.push_back(1'b1);
                  end else begin
                     a = sl_sr[AW:1];
                     sl_rd_cnt++;
                     if (!sl_mute) begin
                        sl_tx.push_back(1'b1);
                        for (int i = 31; i >= 0; i--) sl_tx.push_back(sl_mem[a][i]);
                     end
                  end
                  sl_n = 0;
               end
            end
            sl_prev = sdio_sck;
         end
      end
   end

   // mosi may only change on the clk where sck rises (reset aborts excluded).
   initial begin
      logic p_sck, p_mosi, p_rst;
      p_sck = 0; p_mosi = 0; p_rst = 0;
      forever begin
         @(negedge clk);
         if (rst && p_rst && (sdio_mosi !== p_mosi))
            check("mosi_on_rise", {63'h0, (sdio_sck && !p_sck)}, 64'h1);
         p_sck = sdio_sck; p_mosi = sdio_mosi; p_rst = rst;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic txn(input string tag, input bit wr, input logic [7:0] addr,
                      input logic [31:0] wdata, input bit tmo);
      logic [31:0] exp_rd;
      int k, t0, dt;
      exp_rd = (tmo || wr) ? 32'h0 : ref_mem[addr];
      @(negedge clk);
      cmd_wr = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_valid = 1'b1;
      k = 0;
      while (!cmd_ready && k < 100) begin @(negedge clk); k++; end
      check({tag, ".ready_seen"}, cmd_ready, 1);
      t0 = cyc;
      @(negedge clk);
      cmd_valid = 1'b0;
      check({tag, ".ready_drop"}, cmd_ready, 0);
      k = 0;
      while (!rsp_valid && k < 2000) begin @(negedge clk); k++; end
      check({tag, ".rsp_seen"}, rsp_valid, 1);
      dt = cyc - (t0 + 1);
      check({tag, ".clks"}, dt, exp_clks(wr, tmo));
      check({tag, ".err"}, rsp_err, tmo);
      check({tag, ".rdata"}, rsp_rdata, exp_rd);
      @(negedge clk);
      check({tag, ".pulse"}, rsp_valid, 0);
      if (wr && !tmo) ref_mem[addr] = wdata;
   endtask

   initial begin
      int k, wc, rc, rc0;
      logic [7:0]  ra;
      logic [31:0] rd;
      bit          rw;

      for (int i = 0; i < 256; i++) begin sl_mem[i] = '0; ref_mem[i] = '0; end

      #2 rst = 1'b0;
      @(negedge clk);
      check("rst.sck", sdio_sck, 0);
      check("rst.mosi", sdio_mosi, 0);
      check("rst.ready", cmd_ready, 0);
      check("rst.valid", rsp_valid, 0);
      check("rst.rdata", rsp_rdata, 0);
      check("rst.err", rsp_err, 0);
      rst = 1'b1;
      @(negedge clk);
      check("rst.ready_after", cmd_ready, 1);

      // write then read back
      wc = sl_wr_cnt;
      txn("wr12", 1'b1, 8'h12, 32'hDEADBEEF, 1'b0);
      check("wr12.strobes", sl_wr_cnt - wc, 1);
      check("wr12.addr", sl_last_wa, 8'h12);
      check("wr12.data", sl_last_wd, 32'hDEADBEEF);
      rc = sl_rd_cnt;
      txn("rd12", 1'b0, 8'h12, 32'h0, 1'b0);
      check("rd12.strobes", sl_rd_cnt - rc, 1);
      check("rd12.value", rsp_rdata, 32'hDEADBEEF);

      // alternating-bit pattern at the minimum divider
      txn("wrA5", 1'b1, 8'h3C, 32'hA5A5A5A5, 1'b0);
      txn("rdA5", 1'b0, 8'h3C, 32'h0, 1'b0);

      // randomized traffic against the reference memory
      for (int t = 0; t < 10; t++) begin
         rw = $urandom_range(0, 1);
         ra = 8'($urandom_range(0, 255));
         rd = $urandom;
         txn($sformatf("rand%0d", t), rw, ra, rd, 1'b0);
      end

      // back-to-back with cmd_valid held
      @(negedge clk);
      cmd_wr = 1'b0; cmd_addr = 8'h00; cmd_wdata = 32'h0; cmd_valid = 1'b1;
      k = 0;
      while (!cmd_ready && k < 100) begin @(negedge clk); k++; end
      @(negedge clk);
      cmd_wr = 1'b1; cmd_addr = 8'hFF; cmd_wdata = 32'h00000001;
      k = 0;
      while (!rsp_valid && k < 2000) begin @(negedge clk); k++; end
      check("b2b.first_valid", rsp_valid, 1);
      check("b2b.first_rdata", rsp_rdata, ref_mem[0]);
      check("b2b.first_err", rsp_err, 0);
      check("b2b.ready_with_valid", cmd_ready, 1);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("b2b.second_taken", cmd_ready, 0);
      k = 0;
      while (!rsp_valid && k < 2000) begin @(negedge clk); k++; end
      check("b2b.second_valid", rsp_valid, 1);
      check("b2b.second_err", rsp_err, 0);
      check("b2b.second_rdata", rsp_rdata, 0);
      ref_mem[8'hFF] = 32'h1;
      check("b2b.mem_ff", sl_mem[8'hFF], 32'h1);

      // read timeout with miso held low
      sl_mute = 1;
      txn("tmo", 1'b0, 8'h12, 32'h0, 1'b1);
      sl_mute = 0;

      // reset in the middle of a write frame
      @(negedge clk);
      cmd_wr = 1'b1; cmd_addr = 8'h55; cmd_wdata = 32'hFFFFFFFF; cmd_valid = 1'b1;
      k = 0;
      while (!cmd_ready && k < 100) begin @(negedge clk); k++; end
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (60) @(negedge clk);
      k = 0;
      while (!(sdio_sck && sdio_mosi) && k < 200) begin @(negedge clk); k++; end
      check("abort.sck_hi_before", sdio_sck, 1);
      rc0 = rsp_count;
      #1 rst = 1'b0;
      #1;
      check("abort.sck", sdio_sck, 0);
      check("abort.mosi", sdio_mosi, 0);
      check("abort.ready", cmd_ready, 0);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort.ready_after", cmd_ready, 1);
      check("abort.no_rsp", rsp_count - rc0, 0);
      check("abort.mem_55", sl_mem[8'h55], ref_mem[8'h55]);

      // master and slave both resynchronised by the reset
      txn("post_rst_rd12", 1'b0, 8'h12, 32'h0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sdio_master.md
SDIO_MASTER -- requirements
Module: sdio_master

Interface
REQ-001 Parameter AW, default 8, sets the register address width in bits.
REQ-002 Parameter HALF_DIV, default 8, sets the number of clk cycles per sdio_sck half-period; the minimum is 4.
REQ-003 Parameter TMO, default 8, sets the number of sck cycles to wait for a marker before timeout.
REQ-004 clk  in  1  single block clock; all logic SHALL be on its rising edge.
REQ-005 rst  in  1  reset; asynchronous and active-low.
REQ-006 cmd_valid  in  1  host presents a command.
REQ-007 cmd_ready  out  1  block accepts a command; high only in IDLE.
REQ-008 cmd_wr  in  1  1 = write, 0 = read.
REQ-009 cmd_addr  in  AW  register address.
REQ-010 cmd_wdata  in  32  write data.
REQ-011 rsp_valid  out  1  single-cycle completion pulse; no backpressure.
REQ-012 rsp_rdata  out  32  read data; 0 for writes and on error.
REQ-013 rsp_err  out  1  timeout flag, qualified by rsp_valid.
REQ-014 sdio_sck  out  1  serial clock; idles low.
REQ-015 sdio_mosi  out  1  serial data to the slave.
REQ-016 sdio_miso  in  1  serial data from the slave; asynchronous, synchronised with 2 flops.

Function
REQ-017 A command SHALL be accepted on the cycle where cmd_valid & cmd_ready; its fields SHALL be latched and cmd_ready SHALL drop the next cycle.
REQ-018 Each sck cycle SHALL be low for HALF_DIV clks, then high for HALF_DIV clks; sdio_mosi SHALL change only on the clk where sck rises.
REQ-019 Synchronised sdio_miso SHALL be sampled on the clk where sck falls.
REQ-020 The read frame SHALL send, MSB first: 1, 0, addr[AW-1:0], then one turn bit 0 (AW+3 sck cycles).
REQ-021 The write frame SHALL send, MSB first: 1, 1, addr[AW-1:0], wdata[31:0], then one turn bit 0 (AW+35 sck cycles).
REQ-022 The states SHALL be IDLE -> SEND -> WAIT_MARK -> (RDATA for reads) -> GAP -> IDLE.
REQ-023 In SEND, a down-counter SHALL count frame bits; SEND SHALL exit after the turn bit's falling edge.
REQ-024 In WAIT_MARK, sck SHALL keep toggling with mosi=0; the first sampled miso=1 is the marker.
REQ-025 On a read marker, the block SHALL go to RDATA; on a write marker, it SHALL go to GAP with rsp_err=0.
REQ-026 If no marker is seen within TMO sck cycles, the block SHALL go to GAP, with rsp_err=1 and rsp_rdata=0 at completion.
REQ-027 RDATA SHALL shift in 32 miso samples MSB first on consecutive falling edges.
REQ-028 GAP SHALL clock 2 sck cycles with mosi=0, so the slave returns to its idle state.
REQ-029 rsp_valid SHALL pulse on the clk after the last GAP falling edge; cmd_ready SHALL rise in the same cycle.
REQ-030 A new command MAY be accepted in the same cycle that rsp_valid pulses.
REQ-031 sdio_mosi SHALL be 0 whenever not in SEND, so the slave never decodes a header between frames.
REQ-032 cmd_valid while busy SHALL be ignored; fields are not re-latched.
REQ-033 Timing rule: the slave clock frequency SHALL be at least the clk frequency.

Reset
REQ-034 While rst=0: sdio_sck=0, sdio_mosi=0, cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, and the state is IDLE.
REQ-035 On the first clk after reset release, cmd_ready SHALL be 1.
REQ-036 Reset mid-frame SHALL abort with no rsp_valid; slave resync requires a system-wide reset.

Structure
REQ-037 Package sdio_pkg SHALL hold the state encoding, the header codes (read 2'b10, write 2'b11), the frame-length constants and the GAP length.
REQ-038 Sub-module sdio_sck_gen SHALL hold the HALF_DIV divider, the sck register, and the one-clk rise/fall tick outputs.

Verification
REQ-039 The bench SHALL connect the master to the slave block with a 256x32 register model and slave clk = clk.
REQ-040 Write addr 0x12, data 0xDEADBEEF -> the slave wr strobe fires once with addr 0x12 and data 0xDEADBEEF; rsp_valid pulses with rsp_err=0.
REQ-041 Read addr 0x12 after that write -> rsp_rdata=0xDEADBEEF, rsp_err=0; exactly 1 slave rd strobe.
REQ-042 Back-to-back read addr 0x00 then write addr 0xFF with data 0x00000001, cmd_valid held -> both complete in order; the register model holds 0xFF=1.
REQ-043 miso tied to 0 on a read -> rsp_valid after AW+3+TMO+2 sck cycles, rsp_err=1, rsp_rdata=0.
REQ-044 rst asserted mid write frame -> sck and mosi go to 0 immediately, no rsp_valid, and cmd_ready=1 one clk after release.
REQ-045 HALF_DIV=4 with a read of data 0xA5A5A5A5 -> rsp_rdata=0xA5A5A5A5, with no sampling error.
